// File: rtl/oram_write_sched_if.sv
// Handshake bundle between the translator, the output-RAM write unit and the write scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic's view.
interface oram_write_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              emit_valid;
  logic [DATA_W-1:0] emit_data;
  logic              emit_ready;
  logic              patch_valid;
  logic [ADDR_W-1:0] patch_addr;
  logic [DATA_W-1:0] patch_data;
  logic              patch_ready;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] emit_ptr;
  logic              overflow;
  logic              idle;

  modport slave (
    input  emit_valid, emit_data, patch_valid, patch_addr, patch_data,
    input  base_load, base_addr, wr_ready,
    output emit_ready, patch_ready, wr_start, wr_addr, wr_data,
    output emit_ptr, overflow, idle
  );

  modport master (
    output emit_valid, emit_data, patch_valid, patch_addr, patch_data,
    output base_load, base_addr, wr_ready,
    input  emit_ready, patch_ready, wr_start, wr_addr, wr_data,
    input  emit_ptr, overflow, idle
  );
endinterface

// File: rtl/oram_write_sched.sv
// Shares the single output-RAM write unit between sequential emit appends (via a small FIFO)
// and explicit-address branch back-patches; also owns the emit write pointer.
module oram_write_sched #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  oram_write_sched_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_LO = 2'd2,
    S_WAIT_HI = 2'd3
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] emit_ptr_r;
  logic              overflow_r;
  logic              wr_start_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;

  logic full_s;
  logic empty_s;
  logic arb_ok_s;
  logic patch_win_s;
  logic emit_win_s;
  logic push_s;
  logic pop_s;
  logic idle_s;
  logic base_ok_s;

  // Arbitration: a patch may only win while the FIFO has room, so a full FIFO always drains first.
  always_comb begin
    full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    empty_s     = (count_r == {CNT_W{1'b0}});
    arb_ok_s    = (state_r == S_IDLE) && bus.wr_ready;
    patch_win_s = arb_ok_s && bus.patch_valid && !full_s;
    emit_win_s  = arb_ok_s && !patch_win_s && !empty_s;
    push_s      = bus.emit_valid && !full_s;
    pop_s       = emit_win_s;
    idle_s      = empty_s && (state_r == S_IDLE);
    base_ok_s   = bus.base_load && idle_s && !bus.emit_valid;
  end

  assign bus.emit_ready  = !full_s;
  assign bus.patch_ready = patch_win_s;
  assign bus.idle        = idle_s;
  assign bus.wr_start    = wr_start_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.wr_data     = wr_data_r;
  assign bus.emit_ptr    = emit_ptr_r;
  assign bus.overflow    = overflow_r;

  // FIFO storage array; contents are don't-care until the count says otherwise.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.emit_data;
    end
  end

  // FIFO pointers and occupancy; reset empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Emit pointer advances as each emit word is granted; sticky overflow on wrap past all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      emit_ptr_r <= {ADDR_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (pop_s) begin
      emit_ptr_r <= emit_ptr_r + ADDR_W'(1);
      if (emit_ptr_r == {ADDR_W{1'b1}}) begin
        overflow_r <= 1'b1;
      end
    end else if (base_ok_s) begin
      emit_ptr_r <= bus.base_addr;
    end else begin
      emit_ptr_r <= emit_ptr_r;
    end
  end

  // Write-unit sequencer: grant, one-cycle start, then track the ready low/high handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      wr_start_r <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (patch_win_s) begin
            wr_addr_r  <= bus.patch_addr;
            wr_data_r  <= bus.patch_data;
            wr_start_r <= 1'b1;
            state_r    <= S_ISSUE;
          end else if (emit_win_s) begin
            wr_addr_r  <= emit_ptr_r;
            wr_data_r  <= fifo_mem_r[rd_ptr_r];
            wr_start_r <= 1'b1;
            state_r    <= S_ISSUE;
          end else begin
            wr_start_r <= 1'b0;
          end
        end
        S_ISSUE: begin
          wr_start_r <= 1'b0;
          state_r    <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          wr_start_r <= 1'b0;
          if (!bus.wr_ready) begin
            state_r <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          wr_start_r <= 1'b0;
          if (bus.wr_ready) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          wr_start_r <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oram_write_sched.sv
// Self-checking bench for oram_write_sched: directed table, multi-cycle corner sequences,
// and randomized traffic scored against a queue-based model of emit/patch write streams.
module tb_oram_write_sched;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int                kind;   // 0 emit, 1 patch, 2 base_load
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] exp_waddr;
    logic [DATA_W-1:0] exp_wdata;
    logic [ADDR_W-1:0] exp_ptr;
    logic              exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oram_write_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  oram_write_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  wr_t wlog[$];
  wr_t exp_emit[$];
  wr_t exp_patch[$];
  int  n_vec = 0;
  int  n_fail = 0;
  int  busy = 0;
  int  busy_len = 2;
  int  err_start = 0;
  int  err_hold = 0;
  bit  saw_full;
  logic [ADDR_W-1:0] model_ptr;
  logic              model_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-unit model: ready drops after a start is seen and returns busy_len negedges later.
  initial begin
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    bus.wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.wr_start === 1'b1) begin
        if (busy != 0) err_start++;
        wlog.push_back({bus.wr_addr, bus.wr_data});
        h_addr = bus.wr_addr;
        h_data = bus.wr_data;
        busy = busy_len;
        bus.wr_ready = 1'b0;
      end else if (busy > 0) begin
        if (reset === 1'b1 && (bus.wr_addr !== h_addr || bus.wr_data !== h_data)) err_hold++;
        busy--;
        if (busy == 0) bus.wr_ready = 1'b1;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.emit_valid = 1'b0;
    bus.patch_valid = 1'b0;
    bus.base_load = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    exp_emit.delete();
    exp_patch.delete();
    model_ptr = '0;
    model_ovf = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 2000; i++) begin
      if (bus.idle === 1'b1 && bus.wr_ready === 1'b1 && busy == 0) break;
      tick();
    end
    check("drain_done", 64'(i < 2000), 64'd1);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    int i;
    bus.emit_valid = 1'b1;
    bus.emit_data = d;
    for (i = 0; i < 500; i++) begin
      if (bus.emit_ready === 1'b1) break;
      tick();
    end
    if (i > 0) saw_full = 1'b1;
    check("push_accept", 64'(i < 500), 64'd1);
    tick();
    bus.emit_valid = 1'b0;
    exp_emit.push_back({model_ptr, d});
    if (model_ptr == {ADDR_W{1'b1}}) model_ovf = 1'b1;
    model_ptr = model_ptr + 10'd1;
  endtask

  task automatic do_patch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.patch_valid = 1'b1;
    bus.patch_addr = a;
    bus.patch_data = d;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (bus.patch_ready === 1'b1);
      tick();
    end
    check("patch_accept", 64'(ok), 64'd1);
    bus.patch_valid = 1'b0;
    exp_patch.push_back({a, d});
  endtask

  task automatic base_op(input logic [ADDR_W-1:0] a);
    bit honoured;
    bus.base_load = 1'b1;
    bus.base_addr = a;
    honoured = (bus.idle === 1'b1) && (bus.emit_valid == 1'b0);
    tick();
    bus.base_load = 1'b0;
    if (honoured) model_ptr = a;
  endtask

  task automatic check_log(input string name, input int idx, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    wr_t e;
    check({name, "_present"}, 64'(wlog.size() > idx), 64'd1);
    if (wlog.size() > idx) begin
      e = wlog[idx];
      check({name, "_addr"}, 64'(e.addr), 64'(a));
      check({name, "_data"}, 64'(e.data), 64'(d));
    end
  endtask

  initial begin
    vec_t vt[9];
    int   nlog;
    wr_t  e;
    bit   matched;

    vt[0] = '{0, 10'h000, 32'hE340_0005, 10'h000, 32'hE340_0005, 10'h001, 1'b0};
    vt[1] = '{0, 10'h000, 32'h1234_5678, 10'h001, 32'h1234_5678, 10'h002, 1'b0};
    vt[2] = '{1, 10'h003, 32'hEA00_0010, 10'h003, 32'hEA00_0010, 10'h002, 1'b0};
    vt[3] = '{2, 10'h3FF, 32'h0000_0000, 10'h000, 32'h0000_0000, 10'h3FF, 1'b0};
    vt[4] = '{0, 10'h000, 32'hA5A5_A5A5, 10'h3FF, 32'hA5A5_A5A5, 10'h000, 1'b1};
    vt[5] = '{0, 10'h000, 32'h5A5A_5A5A, 10'h000, 32'h5A5A_5A5A, 10'h001, 1'b1};
    vt[6] = '{2, 10'h010, 32'h0000_0000, 10'h000, 32'h0000_0000, 10'h010, 1'b1};
    vt[7] = '{1, 10'h3FF, 32'hFFFF_FFFF, 10'h3FF, 32'hFFFF_FFFF, 10'h010, 1'b1};
    vt[8] = '{0, 10'h000, 32'h0000_0000, 10'h010, 32'h0000_0000, 10'h011, 1'b1};

    reset = 1'b0;
    bus.emit_valid = 1'b0;
    bus.emit_data = '0;
    bus.patch_valid = 1'b0;
    bus.patch_addr = '0;
    bus.patch_data = '0;
    bus.base_load = 1'b0;
    bus.base_addr = '0;
    repeat (2) tick();
    check("rst_wr_start", 64'(bus.wr_start), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst_wr_data", 64'(bus.wr_data), 64'd0);
    check("rst_emit_ptr", 64'(bus.emit_ptr), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_emit_ready", 64'(bus.emit_ready), 64'd1);
    check("rst_patch_ready", 64'(bus.patch_ready), 64'd0);
    check("rst_idle", 64'(bus.idle), 64'd1);

    apply_reset();
    for (int r = 0; r < 9; r++) begin
      nlog = wlog.size();
      case (vt[r].kind)
        0:       push_word(vt[r].data);
        1:       do_patch(vt[r].addr, vt[r].data);
        default: base_op(vt[r].addr);
      endcase
      drain();
      if (vt[r].kind == 2) begin
        check($sformatf("tbl%0d_nowrite", r), 64'(wlog.size()), 64'(nlog));
      end else begin
        check($sformatf("tbl%0d_count", r), 64'(wlog.size()), 64'(nlog + 1));
        check_log($sformatf("tbl%0d", r), nlog, vt[r].exp_waddr, vt[r].exp_wdata);
      end
      check($sformatf("tbl%0d_emit_ptr", r), 64'(bus.emit_ptr), 64'(vt[r].exp_ptr));
      check($sformatf("tbl%0d_overflow", r), 64'(bus.overflow), 64'(vt[r].exp_ovf));
    end

    // Six back-to-back emits through a four-entry FIFO.
    apply_reset();
    nlog = wlog.size();
    saw_full = 1'b0;
    for (int k = 0; k < 6; k++) push_word(32'hC000_0000 + 32'(k));
    check("b2b_saw_full", 64'(saw_full), 64'd1);
    drain();
    check("b2b_count", 64'(wlog.size()), 64'(nlog + 6));
    for (int k = 0; k < 6; k++)
      check_log($sformatf("b2b%0d", k), nlog + k, 10'(k), 32'hC000_0000 + 32'(k));
    check("b2b_emit_ptr", 64'(bus.emit_ptr), 64'd6);

    // Patch overtakes two emit words still waiting in the FIFO.
    apply_reset();
    nlog = wlog.size();
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
    push_word(32'h3333_3333);
    do_patch(10'h003, 32'hEA00_0010);
    drain();
    check_log("pfirst0", nlog + 0, 10'h000, 32'h1111_1111);
    check_log("pfirst1", nlog + 1, 10'h003, 32'hEA00_0010);
    check_log("pfirst2", nlog + 2, 10'h001, 32'h2222_2222);
    check_log("pfirst3", nlog + 3, 10'h002, 32'h3333_3333);
    check("pfirst_emit_ptr", 64'(bus.emit_ptr), 64'd3);

    // Full FIFO blocks the patch until one emit drains.
    apply_reset();
    nlog = wlog.size();
    for (int k = 0; k < 5; k++) push_word(32'hD000_0000 + 32'(k));
    check("full_emit_ready", 64'(bus.emit_ready), 64'd0);
    bus.patch_valid = 1'b1;
    bus.patch_addr = 10'h100;
    bus.patch_data = 32'hBEEF_0001;
    #1;
    check("full_patch_ready", 64'(bus.patch_ready), 64'd0);
    do_patch(10'h100, 32'hBEEF_0001);
    drain();
    check_log("full0", nlog + 0, 10'h000, 32'hD000_0000);
    check_log("full1", nlog + 1, 10'h001, 32'hD000_0001);
    check_log("full2", nlog + 2, 10'h100, 32'hBEEF_0001);
    check_log("full3", nlog + 3, 10'h002, 32'hD000_0002);
    check_log("full4", nlog + 4, 10'h003, 32'hD000_0003);
    check_log("full5", nlog + 5, 10'h004, 32'hD000_0004);

    // Randomized traffic against the stream model.
    apply_reset();
    nlog = wlog.size();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      #1;
      bus.emit_valid  = ($urandom_range(0, 99) < 45);
      bus.emit_data   = $urandom;
      bus.patch_valid = ($urandom_range(0, 99) < 15);
      bus.patch_addr  = 10'($urandom);
      bus.patch_data  = $urandom;
      bus.base_load   = ($urandom_range(0, 99) < 6);
      bus.base_addr   = 10'($urandom);
      busy_len        = $urandom_range(2, 4);
      #1;
      if (bus.emit_valid && bus.emit_ready === 1'b1) begin
        exp_emit.push_back({model_ptr, bus.emit_data});
        if (model_ptr == {ADDR_W{1'b1}}) model_ovf = 1'b1;
        model_ptr = model_ptr + 10'd1;
      end
      if (bus.patch_valid && bus.patch_ready === 1'b1)
        exp_patch.push_back({bus.patch_addr, bus.patch_data});
      if (bus.base_load && bus.idle === 1'b1 && !bus.emit_valid)
        model_ptr = bus.base_addr;
      @(posedge clk);
    end
    #1;
    bus.emit_valid = 1'b0;
    bus.patch_valid = 1'b0;
    bus.base_load = 1'b0;
    drain();
    for (int i = nlog; i < wlog.size(); i++) begin
      e = wlog[i];
      matched = 1'b0;
      if (exp_patch.size() > 0 && exp_patch[0] == e) begin
        void'(exp_patch.pop_front());
        matched = 1'b1;
      end else if (exp_emit.size() > 0 && exp_emit[0] == e) begin
        void'(exp_emit.pop_front());
        matched = 1'b1;
      end
      if (!matched) $display("rand write %0d unexpected: addr 0x%0h data 0x%0h", i, e.addr, e.data);
      check("rand_write_match", 64'(matched), 64'd1);
    end
    check("rand_emit_left", 64'(exp_emit.size()), 64'd0);
    check("rand_patch_left", 64'(exp_patch.size()), 64'd0);
    check("rand_emit_ptr", 64'(bus.emit_ptr), 64'(model_ptr));
    check("rand_overflow", 64'(bus.overflow), 64'(model_ovf));

    // Reset landing in S_WAIT_HI abandons the write and the queued words.
    apply_reset();
    busy_len = 2;
    base_op(10'h155);
    push_word(32'h7777_0001);
    push_word(32'h7777_0002);
    push_word(32'h7777_0003);
    tick();
    check("mid_busy", 64'(bus.wr_ready), 64'd0);
    nlog = wlog.size();
    reset = 1'b0;
    #1;
    check("mid_wr_start", 64'(bus.wr_start), 64'd0);
    check("mid_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("mid_wr_data", 64'(bus.wr_data), 64'd0);
    check("mid_emit_ptr", 64'(bus.emit_ptr), 64'd0);
    check("mid_overflow", 64'(bus.overflow), 64'd0);
    check("mid_emit_ready", 64'(bus.emit_ready), 64'd1);
    check("mid_patch_ready", 64'(bus.patch_ready), 64'd0);
    check("mid_idle", 64'(bus.idle), 64'd1);
    repeat (4) tick();
    reset = 1'b1;
    repeat (12) tick();
    check("mid_no_writes", 64'(wlog.size()), 64'(nlog));
    check("mid_idle_after", 64'(bus.idle), 64'd1);

    check("start_pulse_errors", 64'(err_start), 64'd0);
    check("hold_errors", 64'(err_hold), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
